// File: rtl/ham_accum_pkg.sv
// Shared definitions for the popcount accumulator and its producers.
package ham_accum_pkg;

  // Default widths shared by the Hamming-weight producer and the register interface.
  localparam int CNT_W_DEF = 6;
  localparam int LEN_W_DEF = 8;

  // Largest legal population count of a 32-bit word.
  localparam int HAM_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ham_len_counter.sv
// Loadable down-counter holding the number of words still expected in a job.
module ham_len_counter
  import ham_accum_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_dec,
  output logic             o_last
);

  logic [LEN_W-1:0] r_rem;

  // Load the job length on an honoured start, count down once per accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_rem <= '0;
    end else if (i_load) begin
      r_rem <= i_len;
    end else if (i_dec) begin
      r_rem <= r_rem - LEN_W'(1);
    end
  end

  // The beat accepted while one word remains completes the job.
  assign o_last = (r_rem == LEN_W'(1));

endmodule

// File: rtl/ham_accum.sv
// Sequential popcount accumulator: sums a programmed number of per-word counts
// received over valid/ready, then reports the total with a one-cycle done pulse.
module ham_accum
  import ham_accum_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int SUM_W = CNT_W + LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_out,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(HAM_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SUM_W-1:0] r_acc;
  logic             r_err;
  logic             w_start_ok;
  logic             w_len_zero;
  logic             w_fire;
  logic             w_last;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_len_zero = (len == '0);
  assign w_fire     = in_valid && in_ready;

  ham_len_counter #(
    .LEN_W (LEN_W)
  ) u_len_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start_ok),
    .i_len  (len),
    .i_dec  (w_fire),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over a beat because it also drops in_ready.
  always_comb begin
    // NOTE: default first so no path through the block leaves a latch behind.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_len_zero ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fire && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        in_ready = !abort;
        busy     = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator and sticky range error; the sum register is the output, so it
  // stays put after done or abort until the next honoured start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else if (w_fire) begin
      r_acc <= r_acc + SUM_W'(in_cnt);
      if (in_cnt > MAX_CNT) begin
        r_err <= 1'b1;
      end
    end
  end

  assign sum_out = r_acc;
  assign err     = r_err;

endmodule

// File: tb/tb_ham_accum.sv
// Self-checking bench for ham_accum: directed scenarios plus randomized jobs,
// checked against job-level expectations computed from the list of counts.
module tb_ham_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_cnt = '0;
  logic        busy;
  logic        done;
  logic [13:0] sum_out;
  logic        err;

  int n_chk = 0;
  int n_err = 0;
  int unsigned q_cnt[$];

  ham_accum dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cnt   (in_cnt),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one job over q_cnt. fixed_gap >= 0 inserts that many idle cycles after
  // each beat; a negative value uses random gaps of gap_pct percent.
  // poke pulses a stray start with a different len while the job is running.
  task automatic run_job(input int n, input int fixed_gap, input int gap_pct, input bit poke);
    int unsigned exp_sum;
    bit          exp_err;
    int          idx;
    int          cycles;
    int          idle_left;
    int          budget;
    exp_sum = 0;
    exp_err = 1'b0;
    foreach (q_cnt[k]) begin
      exp_sum += q_cnt[k];
      if (q_cnt[k] > 32) exp_err = 1'b1;
    end
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    idx = 0;
    cycles = 0;
    idle_left = 0;
    budget = 30 * n + 50;
    while (idx < n && cycles < budget) begin
      if (fixed_gap >= 0) in_valid = (idle_left == 0);
      else in_valid = ($urandom_range(99, 0) >= gap_pct);
      in_cnt = in_valid ? 6'(q_cnt[idx]) : 6'($urandom_range(63, 0));
      if (poke && cycles == 1) begin
        start = 1'b1;
        len   = 8'($urandom_range(255, 1));
      end else begin
        start = 1'b0;
      end
      #1;
      check("accum_ready_done_busy", {in_ready, done, busy}, 3'b101);
      step();
      if (in_valid) begin
        idx++;
        idle_left = fixed_gap;
      end else if (idle_left > 0) begin
        idle_left--;
      end
      cycles++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("beats_accepted", idx, n);
    if (fixed_gap == 0) check("latency", cycles, n);
    // Final cycle: done pulse, final sum. A start here must be ignored.
    start = 1'b1;
    len   = 8'd1;
    #1;
    check("done_ready_done_busy", {in_ready, done, busy}, 3'b011);
    check("sum_out", sum_out, exp_sum);
    check("err", err, exp_err);
    step();
    start = 1'b0;
    check("after_done", {in_ready, done, busy}, 3'b000);
    check("sum_hold", sum_out, exp_sum);
  endtask

  initial begin
    // Reset.
    step();
    step();
    check("rst_ctrl", {in_ready, done, busy, err}, 4'b0000);
    check("rst_sum", sum_out, 0);
    rst = 1'b0;
    // abort in IDLE does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort", {in_ready, done, busy}, 3'b000);

    // Basic job.
    q_cnt = '{32, 0, 7, 1};
    run_job(4, 0, 0, 1'b0);

    // Backpressure with two idle cycles between beats.
    q_cnt = '{5, 5, 5};
    run_job(3, 2, 0, 1'b0);

    // Empty job; abort during DONE must not suppress the pulse.
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    abort = 1'b1;
    #1;
    check("empty_done", {in_ready, done, busy}, 3'b011);
    check("empty_sum", sum_out, 0);
    step();
    abort = 1'b0;
    check("empty_after", {in_ready, done, busy}, 3'b000);

    // Maximum job.
    q_cnt.delete();
    for (int i = 0; i < 255; i++) q_cnt.push_back(32);
    run_job(255, 0, 0, 1'b0);

    // Out-of-range count, then err clears on the next start.
    q_cnt = '{40, 3};
    run_job(2, 0, 0, 1'b0);
    q_cnt = '{1};
    run_job(1, 0, 0, 1'b0);

    // Abort after two beats of 4, with a beat offered alongside abort.
    start = 1'b1;
    len   = 8'd5;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_cnt   = 6'd4;
    step();
    step();
    abort = 1'b1;
    #1;
    check("abort_ready", in_ready, 1'b0);
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle", {in_ready, done, busy}, 3'b000);
    check("abort_sum", sum_out, 8);
    step();
    check("abort_no_done", {done, busy}, 2'b00);

    // Stray start during ACCUM is ignored.
    q_cnt = '{3, 9, 12, 30, 1, 0};
    run_job(6, 0, 0, 1'b1);

    // Reset mid-job after three beats (one out of range).
    start = 1'b1;
    len   = 8'd6;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_cnt = 6'd50;
    step();
    in_cnt = 6'd3;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_ctrl", {in_ready, done, busy, err}, 4'b0000);
    check("midrst_sum", sum_out, 0);
    step();
    check("midrst_no_done", done, 1'b0);
    q_cnt = '{9};
    run_job(1, 0, 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(40, 1);
      q_cnt.delete();
      for (int i = 0; i < n; i++) q_cnt.push_back($urandom_range(40, 0));
      run_job(n, -1, 30, ($urandom_range(3, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ham_accum.md
# ham_accum

Sequential popcount accumulator sitting directly downstream of the 32-bit Hamming-weight unit. It consumes a stream of 6-bit per-word population counts (0..32) over a valid/ready handshake and sums a programmed number of words. It then reports the total with a one-cycle done pulse. It provides the bit-count-over-a-buffer operation, which the single-cycle datapath cannot do in one instruction.

## Interface
Parameters:
- CNT_W, 6, width of each incoming count; legal values are 0..32.
- LEN_W, 8, width of the word-count field; a job covers 1..2^LEN_W−1 words.
- SUM_W, 14 (= CNT_W+LEN_W), width of the total; it cannot overflow, even for illegal inputs.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; honoured only in IDLE.
- len  in  LEN_W  number of words in the job; sampled when start is honoured.
- abort  in  1  cancel the current job; return to IDLE with no done pulse.
- in_valid  in  1  in_cnt carries a count.
- in_ready  out  1  block accepts a count this cycle.
- in_cnt  in  CNT_W  population count of one 32-bit word.
- busy  out  1  high in ACCUM and DONE.
- done  out  1  one-cycle pulse when sum_out becomes final.
- sum_out  out  SUM_W  accumulated total.
- err  out  1  sticky flag: some accepted in_cnt was greater than 32.

## Operation
- States are IDLE, ACCUM and DONE.
- IDLE:
  - in_ready=0 and busy=0.
  - start=1 with len≠0: acc←0, rem←len, err←0, go to ACCUM.
  - start=1 with len=0: acc←0, err←0, go straight to DONE, so sum_out=0.
- ACCUM:
  - in_ready=1, combinationally equal to (state==ACCUM && !abort).
  - A beat transfers when in_valid && in_ready; acc←acc+zero-extended in_cnt and rem←rem−1.
  - A transfer while rem==1 moves to DONE.
  - in_valid without in_ready is ignored; the producer holds its data.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start asserted in DONE is ignored.
- sum_out is a registered copy of acc. It is valid and stable from done until the next honoured start.
- Errors:
  - Any accepted in_cnt >32 sets err.
  - The out-of-range value is still accumulated unchanged.
  - err clears only on an honoured start or on rst.
- abort:
  - Honoured in ACCUM: next state IDLE, no done, sum_out holds the partial sum.
  - A beat presented in the same cycle as abort is not accepted, because in_ready=0.
  - abort in IDLE or DONE has no effect; DONE still pulses.
- start while busy is ignored and len is not resampled.
- Width rule: SUM_W ≥ CNT_W+LEN_W, so acc never wraps.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, sum_out=0, err=0. rst dominates start and abort.
- Reset mid-job discards rem and acc and produces no done pulse.
- start is honoured on edge T; in_ready is high from cycle T+1.
- The last beat is accepted on edge L; done and the final sum_out are visible in cycle L+1.
- The earliest next start is honoured on edge L+2, when the block is back in IDLE.
- Latency from start to done for N words with in_valid held high is N+1 cycles. For len=0 it is 1 cycle.
- Throughput in ACCUM is one count per cycle with no bubbles.

## Structure
- Shared package holds:
  - the state enum (IDLE, ACCUM, DONE);
  - HAM_MAX=32, the legal count limit;
  - default CNT_W and LEN_W, so the producer and the register interface agree on widths.
- One natural sub-module, ham_len_counter: loadable down-counter for rem with a last (rem==1) output.
- The accumulator adder and the state machine stay inline.

## Test plan
- Basic job: rst, start with len=4, counts 32, 0, 7, 1 with in_valid held high → in_ready high for 4 cycles, done 5 cycles after start, sum_out=40, err=0.
- Backpressure gaps: start with len=3, counts 5, 5, 5 with in_valid low for 2 cycles between beats → done one cycle after the third accept, sum_out=15, no extra beats accepted.
- Empty job and maximum job:
  - len=0 → done on the next cycle, sum_out=0.
  - len=255 with all counts 32 → sum_out=8160.
- Error input: start with len=2, counts 40 and 3 → err=1, sum_out=43. A new start with len=1 and count 1 → err=0, sum_out=1.
- Abort and ignored start:
  - start with len=5, 2 beats of 4, then abort → IDLE, no done, sum_out=8.
  - start pulsed during ACCUM of a later job → no effect on rem or acc.
- Reset mid-job: rst after 3 of 6 beats → all outputs return to their reset values; the next job with len=1 and count 9 gives sum_out=9.
